dsp_mac_sequencer: RTL
======================

# dsp_mac_sequencer

Upstream controller for the DSP_Project slice. It accepts a valid/ready stream of (A, B, D) operand tuples grouped into frames, drives the slice's A/B/D/OPMODE inputs so the slice computes the frame sum Σ(D+B)·A in its post-adder accumulator, and returns the 48-bit result plus the term count on a valid/ready output.

## Interface
Parameters:
- MUL_LAT, 3: cycles from driving A/B/D to the product appearing in the slice's M register (DREG, B1REG/A1REG, MREG = 1).
- CNT_W, 16: width of the term counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- s_valid  in  1  operand tuple valid.
- s_ready  out  1  sequencer can accept a tuple.
- s_a  in  18  multiplier operand A.
- s_b  in  18  pre-adder operand B.
- s_d  in  18  pre-adder operand D.
- s_last  in  1  final tuple of the frame.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_d  out  18  to slice D.
- dsp_opmode  out  8  to slice OPMODE; the slice registers it (OPMODEREG = 1).
- dsp_p  in  48  from slice P (PREG = 1).
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts the result.
- m_sum  out  48  frame sum.
- m_count  out  CNT_W  number of terms in the frame.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE/RUN: s_ready = 1. A beat is s_valid & s_ready. On a beat, register s_a/s_b/s_d onto dsp_a/b/d. In cycles without a beat, dsp_a/b/d hold their last value. Enter RUN on the first beat. m_count is 1 for a single-term frame and increments per beat, wrapping modulo 2^CNT_W.
- Each beat pushes a tag {valid = 1, first} into a MUL_LAT-1 deep delay line. Non-beat cycles push {valid = 0}. first = 1 on the first beat of a frame.
- dsp_opmode is driven from the tag at the tail of the delay line:
  - Fixed bits: [7] = 0, [6] = 0 (pre-add), [5] = 0 (carry-in 0), [4] = 1 (select pre-adder).
  - [1:0] = 01 (X = M) if the tail tag is valid, else 00 (X = 0).
  - [3:2] = 00 (Z = 0) if the tail tag is first, else 10 (Z = P).
  - Resulting codes: first term 0x11, accumulate 0x19, bubble 0x18 (P holds).
- On the beat with s_last: go to DRAIN and load a drain counter with MUL_LAT+1. s_ready = 0 in DRAIN and OUT.
- DRAIN: the counter decrements each cycle. When it expires, capture dsp_p into m_sum, set m_valid, and go to OUT.
- OUT: m_valid, m_sum and m_count are held stable until m_valid & m_ready. In the handshake cycle, clear m_valid and return to IDLE. The next beat is accepted in the following cycle.
- Arithmetic is performed by the slice. The 18-bit pre-add wraps and the 48-bit accumulation wraps; the sequencer does not check for overflow.
- Reset, asserted at any time including mid-frame:
  - State returns to IDLE and the tag line is cleared.
  - m_valid = 0, m_sum = 0, m_count = 0.
  - dsp_a/b/d = 0 and dsp_opmode = 0x18.
  - s_ready = 0 while RST is high, and 1 from the first clock edge after release.

## Timing
- Beat at edge t: dsp_a/b/d change at t. The product is in M at t+MUL_LAT. The tail tag drives dsp_opmode at t+MUL_LAT-1, which the slice registers at t+MUL_LAT, and P is updated at t+MUL_LAT+1.
- Last beat at edge t: m_valid rises at t+MUL_LAT+2 (t+5 with the default).
- Throughput: one term per cycle within a frame. Frame overhead is MUL_LAT+2 cycles plus the output handshake.
- Bubbles (s_valid low mid-frame) leave P unchanged and do not alter the result.

## Structure
- Package dsp_pkg holds:
  - OPMODE constants OPM_FIRST = 8'h11, OPM_ACC = 8'h19, OPM_HOLD = 8'h18.
  - The state enum.
  - Widths 18 and 48.
- One sub-module, dsp_tag_pipe: a parameterized-depth shift register of {valid, first} with asynchronous clear.

## Test plan
- Single-term frame (A=2, B=2, D=5, s_last=1) -> m_sum = 14, m_count = 1, m_valid rises 5 cycles after the beat.
- Three back-to-back beats (5,2,2), (9,3,2), (11,5,2) as (D,B,A) -> m_sum = 14+24+32 = 70, m_count = 3.
- Same three tuples with 2 idle cycles between beats -> m_sum = 70; dsp_opmode = 0x18 observed during the bubbles.
- m_ready held low for 6 cycles after m_valid -> m_sum/m_count stable, s_ready = 0 throughout. A second frame (D=1, B=1, A=3) presented during OUT is accepted only after the handshake and gives m_sum = 6 (Z = 0 on its first term).
- RST pulsed mid-frame after 2 beats -> all outputs at reset values. A fresh frame of (5,2,2) with s_last then yields m_sum = 14, m_count = 1.

Source files
------------

// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP slice sequencer: operand and accumulator
// widths, the OPMODE codes driven into the slice, the sequencer state enum,
// and the {valid, first} tag that travels alongside each multiplier term.
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int OP_W = 18;   // A/B/D operand width
    localparam int P_W  = 48;   // accumulator (P) width

    // OPMODE bit map:
    //   [7] carry-in select, [6] pre-add/sub, [5] carry-in,
    //   [4] pre-adder select, [3:2] Z mux, [1:0] X mux.
    localparam logic [7:0] OPM_FIRST = 8'h11;  // P = M
    localparam logic [7:0] OPM_ACC   = 8'h19;  // P = P + M
    localparam logic [7:0] OPM_HOLD  = 8'h18;  // P = P

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    typedef struct packed {
        logic valid;   // a real term is arriving at M
        logic first;   // that term opens a new frame
    } tag_t;

    // A valid tag selects X = M; a first tag selects Z = 0 so the previous
    // frame's P is discarded. Bubbles come out as X = 0, Z = P (hold).
    function automatic logic [7:0] opmode_for(input tag_t tag);
        logic [7:0] opm;
        opm = 8'h10;
        if (tag.valid) begin
            opm[1:0] = 2'b01;
        end
        if (!tag.first) begin
            opm[3:2] = 2'b10;
        end
        return opm;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// -----------------------------------------------------------------------------
// dsp_tag_pipe
// Fixed-depth shift register of {valid, first} tags. It runs in step with
// the slice's multiplier pipeline so that the tag leaving the tail belongs to
// the term about to be registered into M.
//
// Ports:
//   i_clk  in   clock, rising edge
//   i_rst  in   asynchronous, active-high clear
//   i_tag  in   tag pushed every cycle (valid = 0 for bubbles)
//   o_tag  out  tag at the tail, DEPTH cycles after it was pushed
// -----------------------------------------------------------------------------
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_line [DEPTH];

    // NOTE: state updates use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: each stage is cleared because stale tags would produce
            // spurious accumulates after reset; bulk storage arrays would
            // normally be left without a reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_line[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_tag = r_line[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Feeds a frame of (A, B, D) tuples into a DSP slice so that its post-adder
// accumulator builds sum((D + B) * A), then returns the 48-bit result with
// the number of terms in the frame.
//
// Ports:
//   CLK, RST             clock; asynchronous active-high reset
//   s_valid/s_ready      operand stream handshake
//   s_a, s_b, s_d        operands for one term
//   s_last               final term of the frame
//   dsp_a/dsp_b/dsp_d    registered operands to the slice
//   dsp_opmode           registered OPMODE to the slice
//   dsp_p                slice accumulator output
//   m_valid/m_ready      result handshake
//   m_sum, m_count       frame sum and term count
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OP_W-1:0]  s_a,
    input  logic [OP_W-1:0]  s_b,
    input  logic [OP_W-1:0]  s_d,
    input  logic             s_last,
    output logic [OP_W-1:0]  dsp_a,
    output logic [OP_W-1:0]  dsp_b,
    output logic [OP_W-1:0]  dsp_d,
    output logic [7:0]       dsp_opmode,
    input  logic [P_W-1:0]   dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_sum,
    output logic [CNT_W-1:0] m_count
);

    // The opmode register adds one cycle after the tag tail, so the line is
    // one shorter than the multiplier latency.
    localparam int TAG_DEPTH = MUL_LAT - 1;
    // Covers the last term's trip to M, the OPMODE register and the P update.
    localparam int DRAIN_W = $clog2(MUL_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MUL_LAT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run_en;   // keeps s_ready low until the first edge after reset
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [OP_W-1:0]    r_d;
    logic [7:0]         r_opmode;
    logic [DRAIN_W-1:0] r_drain;
    logic [CNT_W-1:0]   r_count;
    logic [P_W-1:0]     r_sum;
    logic               r_m_valid;

    logic               w_accept;
    logic               w_beat;
    logic               w_first;
    logic               w_capture;
    logic               w_release;
    tag_t               w_tag_in;
    tag_t               w_tag_tail;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        w_first     = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                w_accept = r_run_en;
                w_beat   = s_valid & r_run_en;
                w_first  = w_beat & (r_state == IDLE);
                if (w_beat) begin
                    w_state_nxt = s_last ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (r_drain == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                // m_valid is high for the whole of OUT.
                if (m_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_tag_in = '{valid: w_beat, first: w_first};

    dsp_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .i_clk (CLK),
        .i_rst (RST),
        .i_tag (w_tag_in),
        .o_tag (w_tag_tail)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_run_en  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_opmode  <= OPM_HOLD;
            r_drain   <= '0;
            r_count   <= '0;
            r_sum     <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_run_en <= 1'b1;
            r_opmode <= opmode_for(w_tag_tail);

            // Operands only move on a beat; between beats the slice keeps
            // seeing the last term, which is harmless because its tag is a bubble.
            if (w_beat) begin
                r_a     <= s_a;
                r_b     <= s_b;
                r_d     <= s_d;
                r_count <= w_first ? CNT_W'(1) : r_count + 1'b1;
                if (s_last) begin
                    r_drain <= DRAIN_LOAD;
                end
            end else if (r_state == DRAIN && r_drain != '0) begin
                r_drain <= r_drain - 1'b1;
            end

            if (w_capture) begin
                r_sum     <= dsp_p;
                r_m_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready    = w_accept;
    assign dsp_a      = r_a;
    assign dsp_b      = r_b;
    assign dsp_d      = r_d;
    assign dsp_opmode = r_opmode;
    assign m_valid    = r_m_valid;
    assign m_sum      = r_sum;
    assign m_count    = r_count;

endmodule
